// File: rtl/tart_tx_pkg.sv
// Shared definitions for the TART TX unpacker: FSM encoding, byte width and byte-index sizing.
package tart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BYTE_W = 8;

  // One extra index value leaves room for the optional parity byte.
  function automatic int idx_width(input int sample_bytes);
    return $clog2(sample_bytes + 1);
  endfunction

endpackage

// File: rtl/tart_byte_serializer.sv
// Byte serializer: shifts a captured sample word out MSB-byte-first over the tx_valid/tx_ack handshake.
// Optional TX_PARITY_BYTE_EN appends the XOR of the payload bytes as a final byte.
module tart_byte_serializer
  import tart_tx_pkg::*;
#(
  parameter int SAMPLE_BYTES = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           load_i,
  input  logic [BYTE_W*SAMPLE_BYTES-1:0] word_i,
  input  logic                           ack_i,
  output logic [BYTE_W-1:0]              byte_o,
  output logic                           valid_o,
  output logic                           last_ack_o
);

  localparam int W     = BYTE_W * SAMPLE_BYTES;
  localparam int IDX_W = idx_width(SAMPLE_BYTES);
`ifdef TX_PARITY_BYTE_EN
  localparam int LAST_IDX = SAMPLE_BYTES;
`else
  localparam int LAST_IDX = SAMPLE_BYTES - 1;
`endif

  logic [W-1:0]     shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             take;

  assign byte_o     = shift_q[W-1 -: BYTE_W];
  assign valid_o    = valid_q;
  assign take       = valid_q & ack_i;
  assign last_ack_o = take && (idx_q == IDX_W'(LAST_IDX));

`ifdef TX_PARITY_BYTE_EN
  logic [BYTE_W-1:0] par_q, par_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    par_d   = par_q;
    if (load_i) begin
      shift_d = word_i;
      idx_d   = '0;
      valid_d = 1'b1;
      par_d   = '0;
    end else if (last_ack_o) begin
      valid_d = 1'b0;
    end else if (take) begin
      shift_d = shift_q << BYTE_W;
      idx_d   = idx_q + IDX_W'(1);
      par_d   = par_q ^ byte_o;
      // Final payload byte acked: the parity byte takes the top slot next.
      if (idx_q == IDX_W'(SAMPLE_BYTES - 1)) begin
        shift_d[W-1 -: BYTE_W] = par_q ^ byte_o;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_q <= '0;
    end else begin
      par_q <= par_d;
    end
  end
`else
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load_i) begin
      shift_d = word_i;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (last_ack_o) begin
      valid_d = 1'b0;
    end else if (take) begin
      shift_d = shift_q << BYTE_W;
      idx_d   = idx_q + IDX_W'(1);
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/tart_tx_unpacker.sv
// TART TX unpacker: captures SDRAM read words and plays them out byte-wise to SPI, with overrun tracking.
// Build option: define TX_PARITY_BYTE_EN to append a parity byte to every word.
module tart_tx_unpacker
  import tart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_BYTES = 3,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   bb_clk,
  input  logic                   rst,
  input  logic                   data_out_ready,
  input  logic [DATA_WIDTH-1:0]  data_out,
  output logic [7:0]             tx_byte,
  output logic                   tx_valid,
  input  logic                   tx_ack,
  output logic                   spi_buffer_read_complete,
  output logic                   busy,
  output logic                   overrun,
  output logic [COUNT_WIDTH-1:0] overrun_count,
  output logic [COUNT_WIDTH-1:0] words_sent
);

  localparam int PW = BYTE_W * SAMPLE_BYTES;

  state_e                 state_q, state_d;
  logic                   complete_q, complete_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic [COUNT_WIDTH-1:0] ocount_q, ocount_d;
  logic [COUNT_WIDTH-1:0] words_q, words_d;
  logic                   load;
  logic                   last_ack;

  assign load = (state_q == IDLE) && data_out_ready;

  if (DATA_WIDTH > PW) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^data_out[DATA_WIDTH-1:PW];
  end

  tart_byte_serializer #(
    .SAMPLE_BYTES(SAMPLE_BYTES)
  ) u_ser (
    .clk_i     (bb_clk),
    .rst_i     (rst),
    .load_i    (load),
    .word_i    (data_out[PW-1:0]),
    .ack_i     (tx_ack),
    .byte_o    (tx_byte),
    .valid_o   (tx_valid),
    .last_ack_o(last_ack)
  );

  always_ff @(posedge bb_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      ocount_q   <= '0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      complete_q <= complete_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      ocount_q   <= ocount_d;
      words_q    <= words_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (data_out_ready) state_d = SEND;
      SEND:    if (last_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they land registered in the same cycle as the state.
  always_comb begin
    complete_d = (state_d == DONE);
    busy_d     = (state_d != IDLE);
    words_d    = words_q + COUNT_WIDTH'(state_d == DONE);
    overrun_d  = overrun_q;
    ocount_d   = ocount_q;
    if (data_out_ready && (state_q != IDLE)) begin
      overrun_d = 1'b1;
      if (ocount_q != '1) begin
        ocount_d = ocount_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign spi_buffer_read_complete = complete_q;
  assign busy                     = busy_q;
  assign overrun                  = overrun_q;
  assign overrun_count            = ocount_q;
  assign words_sent               = words_q;

endmodule

// File: tb/tb_tart_tx_unpacker.sv
// Self-checking bench for tart_tx_unpacker: table-driven words plus reset, overrun-saturation sequences.
module tb_tart_tx_unpacker;

  localparam int SB = 3;
`ifdef TX_PARITY_BYTE_EN
  localparam int NB = SB + 1;
`else
  localparam int NB = SB;
`endif

  logic        bb_clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_out_ready = 1'b0;
  logic [31:0] data_out = '0;
  logic        tx_ack = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        spi_buffer_read_complete;
  logic        busy;
  logic        overrun;
  logic [7:0]  overrun_count;
  logic [7:0]  words_sent;

  int nChecks = 0;
  int nFail = 0;
  logic [7:0] expQ[$];
  int wordsExp = 0;
  int ocExp = 0;
  logic ovExp = 1'b0;

  typedef struct {
    logic [31:0] word;
    int          ackDelay;
    int          injectAt;
  } vec_t;

  vec_t vecs[6];

  tart_tx_unpacker #(
    .DATA_WIDTH(32),
    .SAMPLE_BYTES(SB),
    .COUNT_WIDTH(8)
  ) dut (
    .bb_clk(bb_clk),
    .rst(rst),
    .data_out_ready(data_out_ready),
    .data_out(data_out),
    .tx_byte(tx_byte),
    .tx_valid(tx_valid),
    .tx_ack(tx_ack),
    .spi_buffer_read_complete(spi_buffer_read_complete),
    .busy(busy),
    .overrun(overrun),
    .overrun_count(overrun_count),
    .words_sent(words_sent)
  );

  always #5 bb_clk = ~bb_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic noteOverrun();
    ovExp = 1'b1;
    if (ocExp < 255) ocExp++;
  endtask

  task automatic strobeWord(input logic [31:0] word);
    logic [7:0] b;
    logic [7:0] par;
    par = 8'h00;
    @(negedge bb_clk);
    data_out_ready = 1'b1;
    data_out = word;
    for (int i = 0; i < SB; i++) begin
      b = word[8*(SB-i)-1 -: 8];
      expQ.push_back(b);
      par = par ^ b;
    end
`ifdef TX_PARITY_BYTE_EN
    expQ.push_back(par);
`endif
    @(negedge bb_clk);
    data_out_ready = 1'b0;
    data_out = 32'h0;
  endtask

  task automatic drainWord(input int ackDelay, input int injectAt);
    logic [7:0] e;
    for (int b = 0; b < NB; b++) begin
      for (int d = 0; d < ackDelay; d++) begin
        tx_ack = 1'b0;
        checkOutput("hold_valid", tx_valid, 1);
        checkOutput("hold_byte", tx_byte, expQ[0]);
        checkOutput("early_complete", spi_buffer_read_complete, 0);
        @(negedge bb_clk);
      end
      checkOutput("valid", tx_valid, 1);
      checkOutput("busy_send", busy, 1);
      checkOutput("early_complete", spi_buffer_read_complete, 0);
      e = expQ.pop_front();
      checkOutput("byte", tx_byte, e);
      tx_ack = 1'b1;
      if (b == injectAt) begin
        data_out_ready = 1'b1;
        data_out = 32'h00C0FFEE;
        noteOverrun();
      end
      @(negedge bb_clk);
      data_out_ready = 1'b0;
    end
    tx_ack = 1'b0;
    checkOutput("done_valid", tx_valid, 0);
    checkOutput("complete", spi_buffer_read_complete, 1);
    if (injectAt == NB) begin
      data_out_ready = 1'b1;
      data_out = 32'h00BADBAD;
      noteOverrun();
    end
    @(negedge bb_clk);
    data_out_ready = 1'b0;
    wordsExp++;
    checkOutput("complete_off", spi_buffer_read_complete, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_valid", tx_valid, 0);
    checkOutput("words_sent", words_sent, wordsExp[7:0]);
    checkOutput("overrun", overrun, ovExp);
    checkOutput("overrun_count", overrun_count, ocExp);
    checkOutput("queue_empty", expQ.size(), 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    strobeWord(v.word);
    drainWord(v.ackDelay, v.injectAt);
  endtask

  initial begin
    vecs[0] = '{32'hFFA1B2C3, 0, -1};
    vecs[1] = '{32'h12345678, 5, -1};
    vecs[2] = '{32'h00ABCDEF, 1, 0};
    vecs[3] = '{32'h000F00F0, 0, -1};
    vecs[4] = '{32'hFF000000, 2, NB};
    vecs[5] = '{32'h00FFFFFF, 0, 1};

    repeat (3) @(negedge bb_clk);
    rst = 1'b0;
    checkOutput("rst_valid", tx_valid, 0);
    checkOutput("rst_byte", tx_byte, 0);
    checkOutput("rst_complete", spi_buffer_read_complete, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_ocount", overrun_count, 0);
    checkOutput("rst_words", words_sent, 0);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Hold a word unacked and flood strobes to drive the overrun counter into saturation.
    strobeWord(32'h00010203);
    for (int i = 0; i < 300; i++) begin
      data_out_ready = 1'b1;
      data_out = 32'h00AA5500 | i;
      noteOverrun();
      @(negedge bb_clk);
      if (i % 50 == 0) checkOutput("ocount_ramp", overrun_count, ocExp);
    end
    data_out_ready = 1'b0;
    checkOutput("ocount_sat", overrun_count, 8'hFF);
    checkOutput("overrun_sticky", overrun, 1);
    drainWord(0, -1);

    // Reset after the first byte has been acked discards the word silently.
    strobeWord(32'h00112233);
    checkOutput("rst_word_b0", tx_byte, expQ.pop_front());
    tx_ack = 1'b1;
    @(negedge bb_clk);
    tx_ack = 1'b0;
    checkOutput("rst_word_b1", tx_byte, expQ[0]);
    rst = 1'b1;
    @(negedge bb_clk);
    rst = 1'b0;
    expQ.delete();
    wordsExp = 0;
    ocExp = 0;
    ovExp = 1'b0;
    checkOutput("midrst_valid", tx_valid, 0);
    checkOutput("midrst_complete", spi_buffer_read_complete, 0);
    checkOutput("midrst_words", words_sent, 0);
    checkOutput("midrst_ocount", overrun_count, 0);
    checkOutput("midrst_overrun", overrun, 0);
    @(negedge bb_clk);
    checkOutput("midrst_no_pulse", spi_buffer_read_complete, 0);
    checkOutput("midrst_idle", busy, 0);
    applyStimulus('{32'h00445566, 0, -1});

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/tart_tx_unpacker.md
# tart_tx_unpacker

Read-side responder for SDRAM acquisition playback. It sits between the SDRAM controller's read-data port and the SPI transmit path on `bb_clk`. It captures each 24-bit sample word returned for a read command issued by the FIFO scheduler in its TX phase, and serialises the word MSB-byte-first to the SPI byte handshake. When the last byte has been taken, it pulses `spi_buffer_read_complete` so the scheduler issues the next read.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of the SDRAM read-data port.
- `SAMPLE_BYTES`, 3, payload bytes per word, taken from `data_out[8*SAMPLE_BYTES-1:0]`.
- `COUNT_WIDTH`, 16, width of the sent-word and overrun counters.

Ports:
- `bb_clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `data_out_ready`  in  1  one-cycle strobe: `data_out` is valid.
- `data_out`  in  DATA_WIDTH  SDRAM read word.
- `tx_byte`  out  8  byte offered to SPI.
- `tx_valid`  out  1  `tx_byte` is valid.
- `tx_ack`  in  1  SPI consumed `tx_byte`; already synchronised to `bb_clk`.
- `spi_buffer_read_complete`  out  1  one-cycle pulse: word fully sent.
- `busy`  out  1  high in any state other than IDLE.
- `overrun`  out  1  sticky: a word arrived while busy.
- `overrun_count`  out  COUNT_WIDTH  dropped words, saturating.
- `words_sent`  out  COUNT_WIDTH  completed words, wraps modulo 2^COUNT_WIDTH.

## Operation
- States: IDLE, SEND, DONE.
- IDLE:
  - On `data_out_ready`, load the shift register with `data_out[8*SAMPLE_BYTES-1:0]` and clear `byte_idx`.
  - Go to SEND.
  - Bits above the payload are ignored.
- SEND:
  - `tx_valid`=1.
  - `tx_byte` = the top byte of the shift register.
  - On `tx_ack`, if `byte_idx` is the last index: go to DONE.
  - On `tx_ack`, otherwise: shift left by 8 and increment `byte_idx`.
  - `tx_valid` stays high across consecutive bytes.
- DONE:
  - `spi_buffer_read_complete`=1 for exactly this cycle.
  - `words_sent` increments.
  - Return to IDLE.
- `data_out_ready` outside IDLE (SEND or DONE):
  - The word is dropped.
  - `overrun` is set.
  - `overrun_count` increments, saturating at all-ones.
  - The word in flight is unaffected.
- `tx_ack` while `tx_valid`=0 is ignored.
- `tx_byte` holds its last value when `tx_valid`=0. It is not required to be zero.
- Reset:
  - All outputs go to 0 and the state goes to IDLE.
  - Reset mid-word discards the partial word without a completion pulse.
  - `overrun` is cleared only by `rst`.

## Timing
- `data_out_ready` in cycle N gives `tx_valid`=1 with byte 0 (`data_out[23:16]`) in cycle N+1.
- `tx_ack` in cycle M with `tx_valid`=1 gives the next byte in cycle M+1.
- The `tx_ack` on the final byte gives `tx_valid`=0 and `spi_buffer_read_complete`=1 in cycle M+1. IDLE is entered at M+2.
- Minimum word period with continuous acks is SAMPLE_BYTES+2 cycles.
- A `data_out_ready` coincident with the completion pulse counts as an overrun.
- `busy` is registered and equal to (state != IDLE).
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- `TX_PARITY_BYTE_EN` defined:
  - After the last payload byte, SEND emits one extra byte: the XOR of all payload bytes.
  - The parity byte is accumulated as each payload byte is acked.
  - The completion pulse follows the ack of the parity byte.
  - The word period becomes SAMPLE_BYTES+3.
- `TX_PARITY_BYTE_EN` undefined: only the payload bytes are sent and no parity logic exists.

## Structure
- Shared package `tart_tx_pkg`:
  - State encoding: IDLE=2'd0, SEND=2'd1, DONE=2'd2.
  - Byte width constant of 8.
  - The `byte_idx` width, derived as clog2(SAMPLE_BYTES+1).
- Sub-module `tart_byte_serializer`:
  - Contains the shift register, `byte_idx`, the parity accumulator, and the `tx_valid`/`tx_ack` handshake.
  - The top level holds the FSM and counters.

## Test plan
- Reset, then `data_out`=32'hFFA1B2C3 strobed, with `tx_ack` held high -> bytes A1, B2, C3 on consecutive cycles, `spi_buffer_read_complete` for one cycle after C3, `words_sent`=1.
- Acks delayed 5 cycles each -> each byte held stable with `tx_valid`=1 until acked; no completion pulse before the third ack.
- Second `data_out_ready` during SEND -> first word output intact, `overrun`=1, `overrun_count`=1; the second word never appears.
- With `TX_PARITY_BYTE_EN` defined, word 24'h0F00F0 -> bytes 0F, 00, F0, FF; completion after the 4th ack.
- `rst` after the first byte is acked -> `tx_valid`=0, no completion pulse, counters 0; the next word sends cleanly from byte 0.
- 300 overruns with COUNT_WIDTH=8 -> `overrun_count` saturates at 8'hFF.
